lava_compositor: RTL

Parametrised successor to the two-ball lava lamp top level. Scans a configurable fixed-point pixel grid and broadcasts each pixel position to `NUM_BALLS` external metaball units. Collects their field values, combines them into a saturated sum and shades the result. Emits one pixel per position on a valid/ready stream toward the frame-buffer writer, and generates a 60 Hz movement strobe that is applied only at frame boundaries.

---
 rtl/lava_pkg.sv | 19 +
 rtl/lava_shade.sv | 41 ++++
 rtl/lava_compositor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lava_pkg.sv
// Shared types for the lava compositor: 16.16 fixed point and the pixel FSM states.
package lava_pkg;

  localparam int FRAC_W = 16;

  typedef logic [31:0] fix_t;

  localparam fix_t FIX_ONE = fix_t'(1) << FRAC_W;
  localparam fix_t FIX_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SUM,
    EMIT
  } comp_state_t;

endpackage

// File: rtl/lava_shade.sv
// Saturating sum of NUM_BALLS field values, shaded to an 8-bit intensity (LAVA_GRADIENT_EN selects gradient).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lava_shade
  import lava_pkg::*;
#(
  parameter int NUM_BALLS = 4,
`ifdef LAVA_GRADIENT_EN
  parameter int GRAD_SHIFT = 8
`else
  parameter fix_t THRESH = FIX_ONE
`endif
) (
  input  logic [32*NUM_BALLS-1:0] vals,
  output logic [7:0]              data
);

  localparam int SW = 32 + $clog2(NUM_BALLS);

  logic [SW-1:0] sum;
  fix_t          sat;

  // Wide enough that NUM_BALLS full-scale values cannot wrap before saturation.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      sum = sum + SW'(vals[32*i +: 32]);
    end
  end

  assign sat = (sum > SW'(FIX_MAX)) ? FIX_MAX : sum[31:0];

`ifdef LAVA_GRADIENT_EN
  fix_t grad;
  assign grad = sat >> GRAD_SHIFT;
  assign data = (grad > 32'd255) ? 8'hFF : grad[7:0];
`else
  assign data = (sat >= THRESH) ? 8'hFF : 8'h00;
`endif

endmodule

// File: rtl/lava_compositor.sv
// Scans an H_RES x V_RES grid, gathers NUM_BALLS field values per pixel and streams shaded pixels (LAVA_GRADIENT_EN: gradient shading).
// Latency: ISSUE, WAIT (>=1), SUM, EMIT -> one pixel per 4 cycles at best.
// Backpressure: EMIT holds out_valid/data until out_ready; scanning stalls meanwhile.
module lava_compositor
  import lava_pkg::*;
#(
  parameter int   NUM_BALLS  = 4,
  parameter int   H_RES      = 32,
  parameter int   V_RES      = 32,
  parameter fix_t STEP       = 32'h0000_8000,
  parameter fix_t MOV_INC    = 32'h0000_0a11,
  parameter fix_t THRESH     = 32'h0001_0000,
  parameter int   GRAD_SHIFT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   px_stb,
  output logic [31:0]            p_x,
  output logic [31:0]            p_y,
  output logic                   mov_en,
  input  logic [NUM_BALLS-1:0]   field_vld,
  input  logic [32*NUM_BALLS-1:0] field,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_sof,
  output logic                   out_eol
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  if (NUM_BALLS < 1 || NUM_BALLS > 16 || GRAD_SHIFT < 0 || GRAD_SHIFT > 31) begin : g_bad_cfg
    $error("lava_compositor: NUM_BALLS must be 1..16 and GRAD_SHIFT 0..31");
  end

  comp_state_t          state, state_nxt;
  logic [XW-1:0]        x_cnt;
  logic [YW-1:0]        y_cnt;
  fix_t                 acc;
  logic [32:0]          acc_sum;
  logic                 mov_pend;
  logic [NUM_BALLS-1:0] mask, mask_nxt;
  fix_t                 cap [NUM_BALLS];
  logic [32*NUM_BALLS-1:0] cap_flat;
  logic [7:0]           shade_dat;
  logic                 at_origin, x_last, y_last, hs;

  assign at_origin = (x_cnt == '0) && (y_cnt == '0);
  assign x_last    = (x_cnt == XW'(H_RES - 1));
  assign y_last    = (y_cnt == YW'(V_RES - 1));
  assign out_valid = (state == EMIT);
  assign hs        = out_valid && out_ready;
  assign acc_sum   = {1'b0, acc} + {1'b0, MOV_INC};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    px_stb    = 1'b0;
    mov_en    = 1'b0;
    mask_nxt  = mask;
    case (state)
      IDLE:  state_nxt = ISSUE;
      ISSUE: begin
        px_stb    = 1'b1;
        mov_en    = at_origin && mov_pend;
        mask_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Look at the updated mask so the last capture goes straight to SUM.
        mask_nxt = mask | field_vld;
        if (&mask_nxt) state_nxt = SUM;
      end
      SUM:   state_nxt = EMIT;
      EMIT:  if (out_ready) state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_flat = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      cap_flat[32*i +: 32] = cap[i];
    end
  end

  lava_shade #(
    .NUM_BALLS (NUM_BALLS),
`ifdef LAVA_GRADIENT_EN
    .GRAD_SHIFT(GRAD_SHIFT)
`else
    .THRESH    (THRESH)
`endif
  ) u_shade (
    .vals(cap_flat),
    .data(shade_dat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      p_x      <= '0;
      p_y      <= '0;
      acc      <= '0;
      mov_pend <= 1'b0;
      mask     <= '0;
      out_data <= '0;
      out_sof  <= 1'b0;
      out_eol  <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) cap[i] <= '0;
    end else begin
      acc  <= acc_sum[31:0];
      mask <= mask_nxt;
      // A fresh carry wins over the clear; requests never stack beyond one.
      if (acc_sum[32])  mov_pend <= 1'b1;
      else if (mov_en)  mov_pend <= 1'b0;
      if (state == WAIT) begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          if (field_vld[i] && !mask[i]) cap[i] <= field[32*i +: 32];
        end
      end
      if (state == SUM) begin
        out_data <= shade_dat;
        out_sof  <= at_origin;
        out_eol  <= x_last;
      end
      if (hs) begin
        if (x_last) begin
          x_cnt <= '0;
          p_x   <= '0;
          if (y_last) begin
            y_cnt <= '0;
            p_y   <= '0;
          end else begin
            y_cnt <= y_cnt + 1'b1;
            p_y   <= p_y + STEP;
          end
        end else begin
          x_cnt <= x_cnt + 1'b1;
          p_x   <= p_x + STEP;
        end
      end
    end
  end

endmodule
